adc_sample_capture: RTL
=======================

Name: adc_sample_capture

Overview:
- Digital stage directly downstream of the SAR ADC slice.
- Synchronises the ADC conversion-done clock (clk_out) into the digital clock domain and captures the 9-bit offset-binary code on each conversion.
- Converts each code to two's complement, subtracts a programmable DC offset with saturation, and boxcar-decimates by 1/2/4/8.
- Delivers the results through a 4-entry valid/ready FIFO to the baseband receiver.

Parameters:
- DATA_W, 9: ADC code width and output sample width.
- ACC_W, 12: accumulator width; must be at least DATA_W+3.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2.

Ports:
- clk  input  1  digital clock; at least 4x the ADC clk_out rate.
- reset  input  1  asynchronous, active-high reset.
- adc_data  input  DATA_W  ADC data_out, offset binary; stable for at least 4 clk cycles after each clk_out rising edge.
- adc_clk_out  input  1  ADC conversion-done clock (asynchronous to clk).
- enable  input  1  capture enable.
- decim_sel  input  2  decimation factor select: 2^decim_sel, i.e. 1, 2, 4 or 8.
- offset  input  DATA_W  signed DC offset subtracted from every sample.
- out_data  output  DATA_W  signed decimated sample (FIFO head).
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts the head entry.
- overflow  output  1  sticky; set when a sample is dropped because the FIFO is full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset (asynchronous, any time, including mid-window): all registers cleared.
  - out_data=0, out_valid=0, overflow=0.
  - Synchroniser flops, accumulator, window counter and FIFO pointers all 0.
- Synchroniser: adc_clk_out passes through flops s1 -> s2 -> s3. strobe = s2 & ~s3, one cycle per clk_out rising edge.
- Stage 0, cycle T with strobe=1 and enable=1: cap <= adc_data.
- Stage 1, cycle T+1:
  - Convert: x = {~cap[8], cap[7:0]}.
  - Compute y = x - offset in 10 bits, saturate to [-256, +255], register as samp with samp_v=1.
- Stage 2, cycle T+2, when samp_v=1:
  - sum = acc + samp (ACC_W signed).
  - Window start (cnt==0): latch decim_sel into dsel. decim_sel changes mid-window take effect only at the next window.
  - If cnt == 2^dsel - 1:
    - result = sum >>> dsel (arithmetic shift, truncation toward -inf), pushed to the FIFO.
    - acc <= 0, cnt <= 0.
  - Otherwise: acc <= sum, cnt <= cnt+1.
- Latency with decim 1 and FIFO empty: out_valid rises in cycle T+3, i.e. 3 clk after strobe. Each push appears on out_valid the cycle after the write.
- FIFO:
  - First-word-fall-through: out_data always shows the head entry.
  - Pop when out_valid & out_ready.
  - Push while full, no pop in the same cycle: sample dropped, overflow <= 1, pointers unchanged.
  - Push and pop in the same cycle while full: both happen, no drop.
  - Push and pop in the same cycle while empty: push only (out_valid was 0).
  - out_data holds its last value when empty; do not rely on it.
- overflow:
  - Clears on overflow_clr.
  - If overflow_clr and a new drop occur in the same cycle, set wins: overflow=1.
- enable=0:
  - strobes are ignored; acc, cnt and samp_v are cleared.
  - The FIFO keeps its contents and continues to drain.
  - A partial window is discarded. Re-enabling starts a fresh window.
- A sample already in stage 1 when enable falls is discarded.
- No back-pressure to the ADC. Loss is signalled only via overflow.

Test Plan:
- Reset, then enable=1, decim_sel=0, offset=0, adc_data=9'h1FF, one clk_out edge.
  - Required: out_data=+255 (9'h0FF), out_valid rises exactly 3 clk after strobe.
- Code conversion and saturation, decim 1:
  - adc_data=9'h000 with offset=+1 -> out_data=-256 (saturated).
  - adc_data=9'h100 with offset=0 -> out_data=0.
  - adc_data=9'h1FF with offset=-5 -> out_data=+255 (saturated).
- Decimation: decim_sel=2, codes 0x100+{3,4,5,7} (signed 3,4,5,7, sum 19).
  - Required: one output 19>>>2=4.
  - Repeat with signed -1,-1,-1,-2 -> output -2 (truncation toward -inf).
- Mid-window change: decim_sel=1 -> 3 after the first sample of a window.
  - Required: that window closes after 2 samples; the next window closes after 8 samples.
- Overflow: out_ready=0, decim 1, 6 strobes.
  - Required: 4 entries held, overflow=1, later entries dropped.
  - Then out_ready=1: entries 1-4 drain in order.
  - Then overflow_clr: overflow=0.
- Async reset mid-window (decim 8 after 5 samples) while the FIFO holds 2 entries.
  - Required: out_valid=0 immediately, overflow=0.
  - Next 8 samples produce exactly one output equal to their mean.

Source files
------------

// File: rtl/adc_sample_capture.sv
// rtl/adc_sample_capture.sv - SAR ADC sample capture, offset removal, boxcar decimation and output FIFO
//
// Ports:
//   clk           digital clock, at least 4x the ADC conversion rate
//   reset         asynchronous active-high reset
//   adc_data      ADC code, offset binary, stable >= 4 clk after adc_clk_out rises
//   adc_clk_out   ADC conversion-done clock, asynchronous to clk
//   enable        capture enable; low discards in-flight samples and partial windows
//   decim_sel     decimation factor 2^decim_sel (1, 2, 4, 8), sampled at window start
//   offset        signed DC offset subtracted from every sample
//   out_data      signed decimated sample at the FIFO head
//   out_valid     FIFO not empty
//   out_ready     consumer accepts the head entry
//   overflow      sticky flag, set when a result is dropped on a full FIFO
//   overflow_clr  clears overflow (a simultaneous drop wins)

module adc_sample_capture #(
  parameter int DATA_W     = 9,
  parameter int ACC_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_clk_out,
  input  logic              enable,
  input  logic [1:0]        decim_sel,
  input  logic [DATA_W-1:0] offset,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Synchroniser and rising-edge detect
  logic s1, s2, s3;
  logic strobe;

  // Pipeline
  logic [DATA_W-1:0]        cap;
  logic                     cap_v;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W:0]   y;
  logic signed [DATA_W-1:0] y_sat;
  logic signed [DATA_W-1:0] samp;
  logic                     samp_v;

  // Decimator
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic [2:0]               cnt;
  logic [1:0]               dsel;
  logic [1:0]               eff_sel;
  logic                     win_last;
  logic                     push;
  logic [DATA_W-1:0]        push_data;

  // FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] head;
  logic              full, empty, pop, do_write, drop;

  assign strobe = s2 & ~s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= adc_clk_out;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Offset binary to two's complement is an MSB flip; the subtraction is one
  // bit wider so the saturation test is a simple top-two-bit disagreement.
  assign x = {~cap[DATA_W-1], cap[DATA_W-2:0]};
  assign y = {x[DATA_W-1], x} - {offset[DATA_W-1], offset};

  always_comb begin
    y_sat = y[DATA_W-1:0];
    if (y[DATA_W] != y[DATA_W-1]) begin
      y_sat = y[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap    <= '0;
      cap_v  <= 1'b0;
      samp   <= '0;
      samp_v <= 1'b0;
    end else begin
      cap_v  <= strobe & enable;
      samp_v <= cap_v & enable;
      if (strobe && enable) cap <= adc_data;
      if (cap_v && enable) samp <= y_sat;
    end
  end

  // The first sample of a window uses decim_sel directly; later samples use
  // the value latched at that first sample.
  assign eff_sel   = (cnt == 3'd0) ? decim_sel : dsel;
  assign sum       = acc + {{(ACC_W-DATA_W){samp[DATA_W-1]}}, samp};
  assign win_last  = (cnt == ((3'd1 << eff_sel) - 3'd1));
  assign push      = samp_v & enable & win_last;
  assign push_data = DATA_W'(sum >>> eff_sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      cnt  <= '0;
      dsel <= '0;
    end else if (!enable) begin
      acc <= '0;
      cnt <= '0;
    end else if (samp_v) begin
      if (cnt == 3'd0) dsel <= decim_sel;
      if (win_last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 3'd1;
      end
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign do_write  = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign head      = mem[rd_ptr[AW-1:0]];
  // When empty, keep showing the last entry that left the FIFO.
  assign out_data  = empty ? hold_q : head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      hold_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        hold_q <= head;
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (drop) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule
